// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx serializer among
// N_REQ byte requesters. It latches the winning byte, strobes send, follows
// busy through the frame, acknowledges the requester and enforces an
// optional inter-frame gap.
module uart_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int RISE_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [7:0]               tx_data,
    output logic                     tx_send,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic                     err
);

    localparam int GW      = $clog2(N_REQ);
    localparam int CNT_MAX = ((RISE_TIMEOUT > GAP_CYCLES) ? RISE_TIMEOUT : GAP_CYCLES) + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RISE_LAST = CW'(RISE_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES);
    localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RISE,
        WAIT_FALL,
        GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     last_next;
    logic [GW-1:0]     grant_next;
    logic [7:0]        data_next;
    logic              send_next;
    logic [N_REQ-1:0]  ack_next;
    logic              err_next;

    logic              pick_valid;
    logic [GW-1:0]     pick_id;
    logic [7:0]        pick_data;

    // Round-robin pick: first set request bit scanning upward from last_grant+1,
    // wrapping, so the requester just served is considered last.
    always_comb begin : arbiter
        int cand;
        pick_valid = 1'b0;
        pick_id    = '0;
        pick_data  = '0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand[GW-1:0];
                pick_data  = req_data[8*cand +: 8];
            end
        end
    end

    // Next-state and next-output logic; the counter is shared between the
    // busy-rise timeout and the inter-frame gap since they never overlap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last_grant;
        grant_next = grant_id;
        data_next  = tx_data;
        send_next  = 1'b0;
        ack_next   = '0;
        err_next   = err;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = SEND;
                    grant_next = pick_id;
                    data_next  = pick_data;
                    send_next  = 1'b1;
                end
            end
            SEND: begin
                state_next = WAIT_RISE;
                cnt_next   = '0;
            end
            WAIT_RISE: begin
                if (tx_busy) begin
                    state_next = WAIT_FALL;
                end else if (cnt == RISE_LAST) begin
                    err_next           = 1'b1;
                    ack_next[grant_id] = 1'b1;
                    last_next          = grant_id;
                    state_next         = GAP;
                    cnt_next           = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!tx_busy) begin
                    ack_next[grant_id] = 1'b1;
                    last_next          = grant_id;
                    state_next         = GAP;
                    cnt_next           = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= LAST_INIT;
            grant_id   <= '0;
            tx_data    <= '0;
            tx_send    <= 1'b0;
            ack        <= '0;
            err        <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_next;
            grant_id   <= grant_next;
            tx_data    <= data_next;
            tx_send    <= send_next;
            ack        <= ack_next;
            err        <= err_next;
            active     <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench for uart_tx_sched with a stub transmitter
// and a behavioural arbitration/timing model.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int RT    = 8;
    localparam int G_GAP = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           err;

    logic [N-1:0]   g_req;
    logic [8*N-1:0] g_req_data;
    logic [N-1:0]   g_ack;
    logic [7:0]     g_tx_data;
    logic           g_tx_send;
    logic           g_tx_busy;
    logic [1:0]     g_grant_id;
    logic           g_active;
    logic           g_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       stub_dead;
    logic       send_seen;
    int         busy_left;
    logic       g_send_seen;
    int         g_busy_left;
    logic       mon_prev_send;

    int         model_last;
    logic [7:0] exp_byte [N];
    int         grant_log [$];

    uart_tx_sched #(.N_REQ(N), .GAP_CYCLES(0), .RISE_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .err(err)
    );

    uart_tx_sched #(.N_REQ(N), .GAP_CYCLES(G_GAP), .RISE_TIMEOUT(RT)) dut_gap (
        .clk(clk), .reset(reset), .req(g_req), .req_data(g_req_data), .ack(g_ack),
        .tx_data(g_tx_data), .tx_send(g_tx_send), .tx_busy(g_tx_busy),
        .grant_id(g_grant_id), .active(g_active), .err(g_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used as the time base for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stub: samples send, raises busy one edge later, random frame length.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_seen <= 1'b0;
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else begin
            send_seen <= tx_send && !stub_dead;
            if (send_seen) begin
                tx_busy   <= 1'b1;
                busy_left <= int'($urandom_range(10, 2));
            end else if (tx_busy) begin
                if (busy_left == 0) tx_busy <= 1'b0;
                else busy_left <= busy_left - 1;
            end
        end
    end

    // Fixed-length transmitter stub for the gap instance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_send_seen <= 1'b0;
            g_tx_busy   <= 1'b0;
            g_busy_left <= 0;
        end else begin
            g_send_seen <= g_tx_send;
            if (g_send_seen) begin
                g_tx_busy   <= 1'b1;
                g_busy_left <= 3;
            end else if (g_tx_busy) begin
                if (g_busy_left == 0) g_tx_busy <= 1'b0;
                else g_busy_left <= g_busy_left - 1;
            end
        end
    end

    // Continuous protocol watch: one-hot ack and single-cycle send.
    always @(negedge clk) begin
        if (ack != '0) begin
            total++;
            if ($countones(ack) != 1) begin
                bad++;
                $display("[TB] FAIL ack_onehot: got %b, need one bit", ack);
            end
        end
        if (tx_send) begin
            total++;
            if (mon_prev_send) begin
                bad++;
                $display("[TB] FAIL send_width: send high two cycles at cyc %0d, need 1", cyc);
            end
        end
        mon_prev_send <= tx_send;
    end

    // Spec rule: first pending requester after the last served one, wrapping.
    function automatic int arb_pick(input logic [N-1:0] pend, input int last);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_request(input int i);
        logic [7:0] d;
        d = 8'($urandom);
        req_data[8*i +: 8] = d;
        exp_byte[i] = d;
        req[i] = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_last = N - 1;
    endtask

    // Serves n_acks frames against the model, then withdraws all requests.
    task automatic run_frames(input int n_acks, input logic [N-1:0] rereq, input int budget);
        int seen, c, fall_cyc, cur_id, last_ack_cyc, exp_id;
        logic prev_busy, in_flight, b2b_pending;
        logic [N-1:0] ev;
        seen = 0; c = 0; fall_cyc = -10; cur_id = 0; last_ack_cyc = -1;
        prev_busy = tx_busy; in_flight = 1'b0; b2b_pending = 1'b0;
        grant_log.delete();
        while (seen < n_acks && c < budget) begin
            @(negedge clk);
            c++;
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            prev_busy = tx_busy;
            if (tx_send) begin
                exp_id = arb_pick(req, model_last);
                grant_log.push_back(int'(grant_id));
                total++;
                if (exp_id < 0 || int'(grant_id) != exp_id) begin
                    bad++;
                    $display("[TB] FAIL grant: got %0d, need %0d", grant_id, exp_id);
                end
                if (exp_id >= 0) begin
                    total++;
                    if (tx_data !== exp_byte[exp_id]) begin
                        bad++;
                        $display("[TB] FAIL tx_data: got %h, need %h", tx_data, exp_byte[exp_id]);
                    end
                    req_data[8*exp_id +: 8] = 8'($urandom);
                    cur_id = exp_id;
                end
                if (b2b_pending) begin
                    total++;
                    if (cyc - last_ack_cyc != 2) begin
                        bad++;
                        $display("[TB] FAIL b2b_spacing: got %0d, need 2", cyc - last_ack_cyc);
                    end
                end
                in_flight = 1'b1;
                b2b_pending = 1'b0;
            end
            if (ack != '0) begin
                seen++;
                ev = '0;
                ev[cur_id] = 1'b1;
                total++;
                if (!in_flight || ack !== ev) begin
                    bad++;
                    $display("[TB] FAIL ack_vec: got %b, need %b", ack, ev);
                end
                total++;
                if (cyc != fall_cyc + 1) begin
                    bad++;
                    $display("[TB] FAIL ack_timing: got cyc %0d, need %0d", cyc, fall_cyc + 1);
                end
                model_last = cur_id;
                in_flight = 1'b0;
                last_ack_cyc = cyc;
                if (seen == n_acks) begin
                    req = '0;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (ack[i]) begin
                            req[i] = 1'b0;
                            if (rereq[i]) set_request(i);
                        end
                    end
                    if (req == '0) set_request(int'($urandom_range(N - 1, 0)));
                end
                b2b_pending = (req != '0);
            end
        end
        total++;
        if (seen < n_acks) begin
            bad++;
            $display("[TB] FAIL frames_budget: got %0d acks, need %0d", seen, n_acks);
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if (tx_send !== 1'b0) begin
                bad++;
                $display("[TB] FAIL drain_send: got send %b, need 0", tx_send);
            end
        end
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drain_active: got %b, need 0", active);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({tx_send, tx_data, ack, grant_id, active, err} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got send=%b data=%h ack=%b gid=%0d act=%b err=%b, need all 0",
                     tx_send, tx_data, ack, grant_id, active, err);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (active !== 1'b0 || tx_send !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_no_req: got act=%b send=%b, need 0 0", active, tx_send);
        end
    endtask

    task automatic test_single();
        req_data[7:0] = 8'hA5;
        exp_byte[0] = 8'hA5;
        req = 4'b0001;
        run_frames(1, 4'b0000, 60);
        total++;
        if (grant_log.size() != 1) begin
            bad++;
            $display("[TB] FAIL single_sends: got %0d, need 1", grant_log.size());
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_err: got %b, need 0", err);
        end
    endtask

    task automatic test_all_four();
        logic [7:0] bytes [N];
        bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'h32; bytes[3] = 8'h43;
        reset_dut();
        for (int i = 0; i < N; i++) begin
            req_data[8*i +: 8] = bytes[i];
            exp_byte[i] = bytes[i];
        end
        req = 4'b1111;
        run_frames(4, 4'b0000, 200);
        total++;
        if (grant_log.size() != 4) begin
            bad++;
            $display("[TB] FAIL all4_count: got %0d, need 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (grant_log[i] != i) begin
                    bad++;
                    $display("[TB] FAIL all4_order[%0d]: got %0d, need %0d", i, grant_log[i], i);
                end
            end
        end
    endtask

    task automatic test_fairness();
        set_request(0);
        set_request(2);
        run_frames(6, 4'b0101, 300);
        for (int i = 0; i < grant_log.size(); i++) begin
            total++;
            if (grant_log[i] != ((i % 2 == 0) ? 0 : 2)) begin
                bad++;
                $display("[TB] FAIL fair_seq[%0d]: got %0d, need %0d", i, grant_log[i], (i % 2 == 0) ? 0 : 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(15, 1));
            for (int i = 0; i < N; i++) if (m[i]) set_request(i);
            run_frames(8, N'($urandom), 400);
        end
    endtask

    task automatic test_timeout();
        int c, s;
        stub_dead = 1'b1;
        set_request(1);
        c = 0;
        s = -1;
        while (s < 0 && c < 20) begin
            @(negedge clk);
            c++;
            if (tx_send) s = cyc;
        end
        total++;
        if (s < 0) begin
            bad++;
            $display("[TB] FAIL timeout_send: got no send, need one");
        end else begin
            while (cyc < s + RT + 1) begin
                @(negedge clk);
                if (cyc < s + RT + 1) begin
                    total++;
                    if (ack !== '0 || err !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL timeout_early: got ack=%b err=%b at +%0d, need 0 0", ack, err, cyc - s);
                    end
                end else begin
                    total++;
                    if (err !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL timeout_err: got %b, need 1", err);
                    end
                    total++;
                    if (ack !== 4'b0010) begin
                        bad++;
                        $display("[TB] FAIL timeout_ack: got %b, need 0010", ack);
                    end
                end
            end
            req = '0;
            model_last = 1;
        end
        stub_dead = 1'b0;
        set_request(2);
        run_frames(1, 4'b0000, 60);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL err_sticky: got %b, need 1", err);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        set_request(0);
        set_request(1);
        set_request(3);
        c = 0;
        while (!tx_busy && c < 30) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_busy: got %b, need 1", tx_busy);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({tx_send, tx_data, ack, grant_id, active, err} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs: got send=%b data=%h ack=%b gid=%0d act=%b err=%b, need all 0",
                     tx_send, tx_data, ack, grant_id, active, err);
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (ack !== '0) begin
                bad++;
                $display("[TB] FAIL mid_no_ack: got %b, need 0", ack);
            end
        end
        reset = 1'b1;
        model_last = N - 1;
        run_frames(3, 4'b0000, 150);
        total++;
        if (grant_log.size() == 0 || grant_log[0] != 0) begin
            bad++;
            $display("[TB] FAIL mid_first_grant: got %0d, need 0", (grant_log.size() == 0) ? -1 : grant_log[0]);
        end
    endtask

    task automatic test_gap();
        int c;
        int send_cyc [$];
        int send_id [$];
        logic [7:0] send_dat [$];
        int ack_cyc [$];
        g_req_data[7:0]  = 8'h11;
        g_req_data[15:8] = 8'h22;
        g_req = 4'b0011;
        c = 0;
        while (ack_cyc.size() < 2 && c < 300) begin
            @(negedge clk);
            c++;
            if (g_tx_send) begin
                send_cyc.push_back(cyc);
                send_id.push_back(int'(g_grant_id));
                send_dat.push_back(g_tx_data);
            end
            if (g_ack != '0) begin
                ack_cyc.push_back(cyc);
                g_req = g_req & ~g_ack;
            end
        end
        total++;
        if (ack_cyc.size() != 2 || send_cyc.size() != 2) begin
            bad++;
            $display("[TB] FAIL gap_count: got %0d sends %0d acks, need 2 2", send_cyc.size(), ack_cyc.size());
        end else begin
            total++;
            if (send_cyc[1] - ack_cyc[0] != G_GAP + 2) begin
                bad++;
                $display("[TB] FAIL gap_spacing: got %0d, need %0d", send_cyc[1] - ack_cyc[0], G_GAP + 2);
            end
            total++;
            if (send_id[0] != 0 || send_id[1] != 1) begin
                bad++;
                $display("[TB] FAIL gap_order: got %0d,%0d, need 0,1", send_id[0], send_id[1]);
            end
            total++;
            if (send_dat[0] !== 8'h11 || send_dat[1] !== 8'h22) begin
                bad++;
                $display("[TB] FAIL gap_data: got %h,%h, need 11,22", send_dat[0], send_dat[1]);
            end
        end
    endtask

    // Hard stop in case a wait somewhere never completes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        reset      = 1'b0;
        req        = '0;
        req_data   = '0;
        g_req      = '0;
        g_req_data = '0;
        stub_dead  = 1'b0;
        model_last = N - 1;
        for (int i = 0; i < N; i++) exp_byte[i] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_gap();
        test_all_four();
        test_fairness();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
